// File: rtl/antares_fetch_pc_if.sv
// Instruction-memory fetch port shared by the IF-stage sequencer and the memory.
//
// Handshake: the master raises imem_req_o with imem_addr_o and holds both stable
// until the slave answers with imem_ready_i. A cycle in which imem_req_o and
// imem_ready_i are both high is one transfer. imem_data_i carries the word for
// imem_addr_o in that same cycle. Any other cycle transfers nothing.
interface antares_fetch_pc_if;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_addr_o,
    output imem_req_o,
    input  imem_ready_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_addr_o,
    input  imem_req_o,
    output imem_ready_i,
    output imem_data_i
  );
endinterface

// File: rtl/antares_fetch_pc.sv
// IF-stage PC register and fetch sequencer. It issues fetches over the imem port
// and holds returned words in a 2-entry skid buffer that feeds the IF/ID register.
// Redirects flush the buffer. A redirect that arrives while a request is waiting
// is parked in a pending slot, so the outstanding address stays stable.
module antares_fetch_pc #(
  parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pc_add4_i,
  input  logic                      exc_taken_i,
  input  logic [31:0]               exc_target_i,
  input  logic                      br_taken_i,
  input  logic [31:0]               br_target_i,
  input  logic                      stall_i,
  output logic [31:0]               pc_o,
  antares_fetch_pc_if.master        imem,
  output logic                      if_valid_o,
  output logic [31:0]               if_pc_o,
  output logic [31:0]               if_instr_o,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_REQ   = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  state_t      state;
  logic        req_q;
  logic        pend_v;
  logic [31:0] pend_pc;
  logic [1:0]  cnt;
  logic [31:0] tail_pc;
  logic [31:0] tail_instr;

  logic        redir;
  logic [31:0] target;
  logic        ack;
  logic        pop;
  logic        push;
  logic [1:0]  cnt_next;
  logic        room;

  assign imem.imem_addr_o = pc_o;
  assign imem.imem_req_o  = req_q;
  assign if_valid_o       = (cnt != 2'd0);
  assign dbg_state        = state;

  // Handshake qualifiers and buffer occupancy for this cycle.
  always_comb begin
    redir  = exc_taken_i | br_taken_i;
    target = exc_taken_i ? exc_target_i : br_target_i;
    ack    = req_q & imem.imem_ready_i;
    pop    = if_valid_o & ~stall_i;
    // A response for an address that was already redirected away is dropped.
    push   = ack & ~redir & ~pend_v;
    cnt_next = cnt + {1'b0, push} - {1'b0, pop};
    // Only issue when the word can land without overflowing the 2-entry buffer.
    room   = (cnt_next <= 2'd1);
  end

  // Fetch sequencer: state, request line, PC and pending redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RESET;
      req_q   <= 1'b0;
      pc_o    <= PC_RESET;
      pend_v  <= 1'b0;
      pend_pc <= 32'd0;
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_REQ;
          req_q <= 1'b1;
          if (redir) pc_o <= target;
        end
        ST_REQ: begin
          if (ack) begin
            if (pend_v)     pc_o <= pend_pc;
            else if (redir) pc_o <= target;
            else            pc_o <= pc_add4_i;
            pend_v <= 1'b0;
            if (redir || room) begin
              state <= ST_REQ;
              req_q <= 1'b1;
            end else begin
              state <= ST_IDLE;
              req_q <= 1'b0;
            end
          end else if (redir) begin
            pend_v  <= 1'b1;
            pend_pc <= target;
          end
        end
        ST_IDLE: begin
          if (redir) begin
            pc_o  <= target;
            state <= ST_REQ;
            req_q <= 1'b1;
          end else if (room) begin
            state <= ST_REQ;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_RESET;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry skid buffer; the head entry drives the IF/ID outputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 2'd0;
      if_pc_o    <= 32'd0;
      if_instr_o <= 32'd0;
      tail_pc    <= 32'd0;
      tail_instr <= 32'd0;
    end else if (redir) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt_next;
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            if_pc_o    <= pc_o;
            if_instr_o <= imem.imem_data_i;
          end else begin
            tail_pc    <= pc_o;
            tail_instr <= imem.imem_data_i;
          end
        end
        2'b01: begin
          if_pc_o    <= tail_pc;
          if_instr_o <= tail_instr;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            if_pc_o    <= pc_o;
            if_instr_o <= imem.imem_data_i;
          end else begin
            if_pc_o    <= tail_pc;
            if_instr_o <= tail_instr;
            tail_pc    <= pc_o;
            tail_instr <= imem.imem_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_antares_fetch_pc.sv
// Bench for antares_fetch_pc: reset checks, a table of directed cycles from reset,
// hand-written redirect/reset sequences, and a long random run against a
// queue-based reference model of the fetch rules.
module tb_antares_fetch_pc;

  localparam logic [31:0] PC_RESET = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_add4;
  logic        exc_taken;
  logic [31:0] exc_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        ready;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  antares_fetch_pc_if imem ();

  antares_fetch_pc #(.PC_RESET(PC_RESET)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_add4_i    (pc_add4),
    .exc_taken_i  (exc_taken),
    .exc_target_i (exc_target),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .stall_i      (stall),
    .pc_o         (pc),
    .imem         (imem),
    .if_valid_o   (if_valid),
    .if_pc_o      (if_pc),
    .if_instr_o   (if_instr),
    .dbg_state    (dbg_state)
  );

  // Instruction memory content: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
  endfunction

  // The adder and the memory are modelled as plain combinational logic.
  assign pc_add4           = pc + 32'd4;
  assign imem.imem_ready_i = ready;
  assign imem.imem_data_i  = mem_word(imem.imem_addr_o);

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: request flag, PC, pending redirect, and the buffer as a queue.
  logic        m_boot;
  logic        m_req;
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_pc;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot    = 1'b1;
    m_req     = 1'b0;
    m_pc      = PC_RESET;
    m_pend_v  = 1'b0;
    m_pend_pc = 32'd0;
    exp_q.delete();
  endtask

  task automatic model_check();
    chk("m_req", {31'd0, imem.imem_req_o}, {31'd0, m_req});
    chk("m_addr", imem.imem_addr_o, m_pc);
    chk("m_pc", pc, m_pc);
    chk("m_valid", {31'd0, if_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("m_if_pc", if_pc, exp_q[0][63:32]);
      chk("m_if_instr", if_instr, exp_q[0][31:0]);
    end
  endtask

  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    logic        ack;
    logic        pop;
    logic        push;
    redir = exc_taken | br_taken;
    tgt   = exc_taken ? exc_target : br_target;
    if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
      if (redir) m_pc = tgt;
    end else begin
      ack  = m_req & ready;
      pop  = (exp_q.size() != 0) & ~stall;
      push = ack & ~redir & ~m_pend_v;
      if (redir) exp_q.delete();
      else begin
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back({m_pc, mem_word(m_pc)});
      end
      if (m_req) begin
        if (ack) begin
          m_pc     = m_pend_v ? m_pend_pc : (redir ? tgt : m_pc + 32'd4);
          m_pend_v = 1'b0;
          m_req    = redir || (exp_q.size() <= 1);
        end else if (redir) begin
          m_pend_v  = 1'b1;
          m_pend_pc = tgt;
        end
      end else if (redir) begin
        m_pc  = tgt;
        m_req = 1'b1;
      end else if (exp_q.size() <= 1) begin
        m_req = 1'b1;
      end
    end
  endtask

  // Driver: inputs change just after the falling edge, outputs are sampled 1ns later.
  task automatic apply(input logic rdy, input logic stl, input logic b, input logic [31:0] bt,
                       input logic e, input logic [31:0] et);
    ready      = rdy;
    stall      = stl;
    br_taken   = b;
    br_target  = bt;
    exc_taken  = e;
    exc_target = et;
    #1;
  endtask

  task automatic apply_plain(input logic rdy, input logic stl);
    apply(rdy, stl, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Compare against the model, advance it across the rising edge, and wait for the next falling edge.
  task automatic finish_cycle();
    model_check();
    model_step();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem.imem_req_o}, 32'd0);
    chk({tag, "_addr"}, imem.imem_addr_o, PC_RESET);
    chk({tag, "_pc"}, pc, PC_RESET);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'd0);
  endtask

  typedef struct {
    logic        ready;
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ifpc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Directed cycles from reset release: back-to-back fetch, then a 5-cycle stall.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0000};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0004};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0008};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_0008};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_0008};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_0008};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_0008};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_0008};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0014, 1'b1, 32'hBFC0_0010};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0018, 1'b1, 32'hBFC0_0014};

    rst = 1'b1;
    apply_plain(1'b0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply_plain(vecs[i].ready, vecs[i].stall);
      chk($sformatf("vec%0d_req", i), {31'd0, imem.imem_req_o}, {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d_addr", i), imem.imem_addr_o, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].exp_ifpc);
        chk($sformatf("vec%0d_if_instr", i), if_instr, mem_word(vecs[i].exp_ifpc));
      end
      finish_cycle();
    end

    // Redirect to 0x100, stall memory, redirect to 0x400 while waiting.
    apply(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'd0);
    finish_cycle();
    apply(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'd0);
    chk("wait_addr0", imem.imem_addr_o, 32'h100);
    chk("wait_valid0", {31'd0, if_valid}, 32'd0);
    finish_cycle();
    apply_plain(1'b0, 1'b0);
    chk("wait_addr1", imem.imem_addr_o, 32'h100);
    chk("wait_req1", {31'd0, imem.imem_req_o}, 32'd1);
    finish_cycle();
    apply_plain(1'b1, 1'b0);
    chk("wait_addr2", imem.imem_addr_o, 32'h100);
    finish_cycle();
    apply_plain(1'b1, 1'b0);
    chk("redir_addr", imem.imem_addr_o, 32'h400);
    chk("drop_valid", {31'd0, if_valid}, 32'd0);
    finish_cycle();
    apply_plain(1'b1, 1'b0);
    chk("flush_valid", {31'd0, if_valid}, 32'd1);
    chk("flush_if_pc", if_pc, 32'h400);
    finish_cycle();

    // Branch and exception on the same acked cycle: exception wins.
    apply(1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 32'h8000_0180);
    finish_cycle();
    apply_plain(1'b1, 1'b0);
    chk("exc_addr", imem.imem_addr_o, 32'h8000_0180);
    chk("exc_valid", {31'd0, if_valid}, 32'd0);
    finish_cycle();
    apply_plain(1'b1, 1'b0);
    chk("exc_if_pc", if_pc, 32'h8000_0180);
    finish_cycle();

    // Fill the buffer, then assert reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) begin
      apply_plain(1'b1, 1'b1);
      finish_cycle();
    end
    apply_plain(1'b0, 1'b1);
    chk("full_valid", {31'd0, if_valid}, 32'd1);
    chk("full_req", {31'd0, imem.imem_req_o}, 32'd0);
    finish_cycle();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply_plain(1'b1, 1'b0);
    chk("rel_req0", {31'd0, imem.imem_req_o}, 32'd0);
    finish_cycle();
    apply_plain(1'b1, 1'b0);
    chk("rel_req1", {31'd0, imem.imem_req_o}, 32'd1);
    chk("rel_addr1", imem.imem_addr_o, PC_RESET);
    finish_cycle();

    // Random ready/stall/redirect traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      logic rdy;
      logic stl;
      logic b;
      logic e;
      rdy = ($urandom_range(0, 9) < 7);
      stl = ($urandom_range(0, 9) < 3);
      b   = ($urandom_range(0, 99) < 4);
      e   = ($urandom_range(0, 99) < 2);
      apply(rdy, stl, b, $urandom & 32'hFFFF_FFFC, e, $urandom & 32'hFFFF_FFFC);
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
